paddle_ctrl: RTL
================

# paddle_ctrl

Converts the keyboard-decoded control levels (`left`, `right`, `level[3:0]`) into a clamped horizontal paddle position for the Breakout game. Sits directly downstream of the PS/2 keycode receiver. Resynchronises its asynchronous outputs into the system clock domain and steps the paddle once per frame tick, at a speed set by the selected level. Feeds `paddle_x` to the renderer and collision logic.

## Interface
- `SCREEN_W`, 640, visible width in pixels
- `PADDLE_W`, 80, paddle width in pixels
- `TICK_DIV`, 1666667, clk cycles per motion tick (100 MHz / 60 Hz)
- `X_W`, 10, width of `paddle_x`

Ports:
- `clk`  in  1  system clock; every register in the block runs on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `left`  in  1  "A" held; driven from the PS/2 clock domain, asynchronous to `clk`
- `right`  in  1  "D" held; asynchronous
- `level`  in  4  selected level 1..8; asynchronous
- `paddle_x`  out  X_W  left edge of paddle, range 0..SCREEN_W-PADDLE_W
- `tick`  out  1  one-cycle motion-tick pulse
- `level_q`  out  4  accepted level
- `level_chg`  out  1  one-cycle pulse when `level_q` changes
- `dir`  out  2  last tick's command: 10 = left, 01 = right, 00 = idle

## Operation
- Each of `left`, `right` and every bit of `level` passes through a 2-flop synchroniser. Synchronised values are `l_s`, `r_s`, `lv_s`.
- Constants: XMAX = SCREEN_W-PADDLE_W (560); CENTRE = XMAX/2 (280).
- Tick counter runs 0..TICK_DIV-1. `tick` is high during the cycle the count equals TICK_DIV-1; the count wraps to 0 on the next edge.
- Level acceptance (checked every cycle):
  - If `lv_s` is in 1..8 and differs from `level_q`: `level_q` <= `lv_s`, `level_chg` = 1 for one cycle, `paddle_x` <= CENTRE, hold counter cleared.
  - `lv_s` of 0 or 9..15 is ignored.
  - Level acceptance overrides any motion step on the same edge.
- Motion (on the edge where `tick`=1 and no level change):
  - Step = `level_q`, zero-extended to X_W+1 bits.
  - `l_s` & !`r_s`: `paddle_x` <= (`paddle_x` < step) ? 0 : `paddle_x`-step; `dir` <= 10.
  - `r_s` & !`l_s`: `paddle_x` <= (`paddle_x`+step > XMAX) ? XMAX : `paddle_x`+step; `dir` <= 01. The sum is computed in X_W+1 bits.
  - Both or neither held: `paddle_x` unchanged; `dir` <= 00.
  - `dir` reports the command even when the position is clamped.
- Reset values: `paddle_x`=CENTRE, `level_q`=1, `tick`=0, `level_chg`=0, `dir`=00, tick counter 0, synchronisers 0, hold counter 0.

## Timing
- Input-to-visible latency: 2 cycles of synchronisation, then the next tick edge.
- A level change appears on `level_q`/`level_chg` 3 edges after `level` settles: 2 synchroniser edges plus 1 compare edge.
- `paddle_x`, `dir` and `level_q` are registered; they change only on a tick edge or a level-accept edge.
- Reset asserted mid-operation clears all state immediately, independent of `clk`. The tick counter restarts from 0 after release.

## Configuration
- `PADDLE_ACCEL_EN` defined:
  - A 3-bit hold counter increments on each tick that repeats the previous tick's direction, saturating at 7.
  - It clears on a direction change, idle, both held, or level accept.
  - The first tick of a new direction uses a count of 0.
  - Step = 2×`level_q` when count ≥ 4, else `level_q`.
- `PADDLE_ACCEL_EN` undefined: the hold counter is not built; step is always `level_q`.

## Test plan
All scenarios run with bench TICK_DIV = 4.
- Reset released with all inputs at 0 -> `paddle_x`=280, `level_q`=1, `dir`=00, `tick` high every 4th cycle.
- `right`=1, `level_q`=1, 10 ticks -> `paddle_x`=290, `dir`=01. Then `left`=`right`=1 for 5 ticks -> `paddle_x`=290, `dir`=00.
- `level`=8, `left` held from 280 -> `paddle_x`=0 after 35 ticks and stays 0 for 5 more ticks; `dir` stays 10.
- From `paddle_x`=300 drive `level`=3 -> exactly one `level_chg` pulse, `level_q`=3, `paddle_x`=280. Then `level`=0, then 9 -> no pulse, `level_q` stays 3.
- `level`=2, `right` held 6 ticks from 280 -> 296 with `PADDLE_ACCEL_EN` defined, 292 without. Assert `rst_n` low mid-hold -> `paddle_x`=280 before the next clk edge.

Source files
------------

// File: rtl/paddle_ctrl.sv
// Breakout paddle controller: resynchronises keyboard levels and steps a clamped paddle position once per motion tick.
// Optional hold-to-accelerate behaviour is built only when PADDLE_ACCEL_EN is defined.
module paddle_ctrl #(
  parameter int SCREEN_W = 640,
  parameter int PADDLE_W = 80,
  parameter int TICK_DIV = 1666667,
  parameter int X_W      = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           left,
  input  logic           right,
  input  logic [3:0]     level,
  output logic [X_W-1:0] paddle_x,
  output logic           tick,
  output logic [3:0]     level_q,
  output logic           level_chg,
  output logic [1:0]     dir
);

  localparam int             XMAX_I = SCREEN_W - PADDLE_W;
  localparam logic [X_W-1:0] XMAX   = X_W'(XMAX_I);
  localparam logic [X_W-1:0] CENTRE = X_W'(XMAX_I / 2);
  localparam int             CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  localparam logic [1:0] DIR_IDLE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  // Two-flop synchronisers, one per asynchronous input bit: {level, right, left}.
  logic [5:0] async_in;
  logic [5:0] sync_vec;

  assign async_in = {level, right, left};

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= async_in[gi];
          sync_reg <= meta_reg;
        end
      end

      assign sync_vec[gi] = sync_reg;
    end
  endgenerate

  logic       l_s;
  logic       r_s;
  logic [3:0] lv_s;

  assign l_s  = sync_vec[0];
  assign r_s  = sync_vec[1];
  assign lv_s = sync_vec[5:2];

  // Motion tick divider; tick is decoded from the registered count.
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_MAX) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == CNT_MAX);

  // Only levels 1..8 are legal; anything else on the keyboard side is ignored.
  logic lv_legal;
  logic accept;

  assign lv_legal = (lv_s >= 4'd1) && (lv_s <= 4'd8);
  assign accept   = lv_legal && (lv_s != level_q);

  logic       cmd_left;
  logic       cmd_right;
  logic [1:0] dir_cmd;

  assign cmd_left  = l_s & ~r_s;
  assign cmd_right = r_s & ~l_s;
  assign dir_cmd   = cmd_left ? DIR_LEFT : (cmd_right ? DIR_RIGHT : DIR_IDLE);

  logic [X_W:0] step;

`ifdef PADDLE_ACCEL_EN
  // Hold count in effect for this tick: 0 on a new direction, else previous count + 1 (saturating).
  logic [2:0] hold_reg;
  logic [2:0] hold_next;

  always_comb begin
    hold_next = 3'd0;
    if ((dir_cmd != DIR_IDLE) && (dir_cmd == dir)) begin
      hold_next = (hold_reg == 3'd7) ? 3'd7 : hold_reg + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg <= 3'd0;
    end else if (accept) begin
      hold_reg <= 3'd0;
    end else if (tick) begin
      hold_reg <= hold_next;
    end
  end

  assign step = (hold_next >= 3'd4) ? (X_W+1)'({level_q, 1'b0}) : (X_W+1)'(level_q);
`else
  assign step = (X_W+1)'(level_q);
`endif

  // Clamped next position; the sum is one bit wider so overflow past XMAX is visible.
  logic [X_W:0]   pos_ext;
  logic [X_W:0]   sum;
  logic [X_W-1:0] pos_next;

  assign pos_ext = {1'b0, paddle_x};

  always_comb begin
    pos_next = paddle_x;
    sum      = pos_ext + step;
    if (cmd_left) begin
      pos_next = (pos_ext < step) ? '0 : X_W'(pos_ext - step);
    end else if (cmd_right) begin
      pos_next = (sum > {1'b0, XMAX}) ? XMAX : X_W'(sum);
    end
  end

  // Level acceptance has priority over a motion step on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddle_x  <= CENTRE;
      level_q   <= 4'd1;
      level_chg <= 1'b0;
      dir       <= DIR_IDLE;
    end else begin
      level_chg <= accept;
      if (accept) begin
        level_q  <= lv_s;
        paddle_x <= CENTRE;
      end else if (tick) begin
        paddle_x <= pos_next;
        dir      <= dir_cmd;
      end
    end
  end

endmodule
